// File: rtl/ram_port_initiator.sv
// Request front-end for one block-RAM port: combinational RAM drive plus an in-order,
// credit-protected response FIFO. Define RAM_PORT_INITIATOR_WRITE_ACK_EN to make writes return acks.
module ram_port_initiator #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int RSP_DEPTH = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_we_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

`ifdef RAM_PORT_INITIATOR_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic             fire, rsp_fire, push, pop;
  logic             pend_q, pend_we_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W:0]   used;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  rsp_t             mem_q [RSP_DEPTH];
  rsp_t             push_rsp, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits count both queued entries and the read still in the RAM pipe,
  // so a stalled consumer can never overflow the FIFO.
  assign used        = (CNT_W+1)'(count_q) + (CNT_W+1)'(pend_q);
  assign req_ready_o = rst_ni && (used < (CNT_W+1)'(RSP_DEPTH));
  assign fire        = req_valid_i && req_ready_o;
  assign rsp_fire    = fire && (WACK || !req_we_i);

  assign ram_we_o    = rst_ni && fire && req_we_i;
  assign ram_addr_o  = req_addr_i;
  assign ram_wdata_o = req_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q    <= 1'b0;
      pend_we_q <= 1'b0;
    end else begin
      pend_q    <= rsp_fire;
      pend_we_q <= rsp_fire && req_we_i;
    end
  end

  assign push          = pend_q;
  assign pop           = rsp_valid_o && rsp_ready_i;
  assign push_rsp.we   = pend_we_q;
  assign push_rsp.data = pend_we_q ? '0 : ram_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_rsp;
  end

  // Outputs are masked when empty so stale storage never leaks out.
  assign head        = mem_q[rd_ptr_q];
  assign rsp_valid_o = (count_q != '0);
  assign rsp_rdata_o = rsp_valid_o ? head.data : '0;
  assign rsp_we_o    = WACK && rsp_valid_o && head.we;

endmodule

// File: tb/tb_ram_port_initiator.sv
// Directed and random bench for ram_port_initiator with a registered-address RAM model.
module tb_ram_port_initiator;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 3;
`ifdef RAM_PORT_INITIATOR_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready_o, rsp_valid_o, rsp_we_o, ram_we_o;
  logic [DATA_W-1:0] rsp_rdata_o, ram_wdata_o, ram_rdata;
  logic [ADDR_W-1:0] ram_addr_o, raddr_q;

  logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] sb_mem [0:(1<<ADDR_W)-1];

  int   errors = 0, checks = 0, fires = 0, cyc = 0;
  logic last_fire, last_rdy, last_ram_we;
  rsp_t obs_q[$];
  int   pop_cyc[$];

  ram_port_initiator #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RSP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
    .rsp_we_o(rsp_we_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
    raddr_q <= ram_addr_o;
  end
  assign ram_rdata = ram[raddr_q];

  // One cycle: drive at edge+1, sample at edge+2, advance past the next edge.
  task automatic step(input logic v, input logic we, input int a, input int d, input logic rr);
    rsp_t r;
    req_valid = v; req_we = we; req_addr = ADDR_W'(a); req_wdata = DATA_W'(d); rsp_ready = rr;
    #1;
    last_rdy    = req_ready_o;
    last_fire   = v && req_ready_o;
    last_ram_we = ram_we_o;
    if (last_fire) fires++;
    if (rsp_valid_o && rr) begin
      r.we = rsp_we_o; r.data = rsp_rdata_o;
      obs_q.push_back(r);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk); cyc++; #1;
  endtask

  task automatic send(input logic we, input int a, input int d, input logic rr);
    int n = 0;
    do begin
      step(1'b1, we, a, d, rr);
      n++;
    end while (!last_fire && n < 50);
    if (!last_fire) begin
      checks++; errors++;
      $display("FAIL send_timeout addr=%0d never accepted within 50 cycles", a);
    end
  endtask

  task automatic idle(input int n, input logic rr);
    repeat (n) step(1'b0, 1'b0, 0, 0, rr);
  endtask

  task automatic test_reset;
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd9; req_wdata = 32'h1234;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", req_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid_o); end
    checks++; if (rsp_rdata_o !== '0) begin errors++; $display("FAIL rst_rsp_rdata got=%h want=0", rsp_rdata_o); end
    checks++; if (rsp_we_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_we got=%b want=0", rsp_we_o); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL rst_ram_we got=%b want=0", ram_we_o); end
    rst_n = 1'b1; req_valid = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", req_ready_o); end
    @(posedge clk); cyc++; #1;
  endtask

  task automatic test_write_read;
    obs_q.delete();
    send(1'b1, 5, 32'hDEADBEEF, 1'b1);
    checks++; if (last_ram_we !== 1'b1) begin errors++; $display("FAIL wr_ram_we got=%b want=1", last_ram_we); end
    send(1'b0, 5, 0, 1'b1);
    // one cycle after the read fire: only a write ack may be visible
    checks++; if (rsp_valid_o !== ACK) begin errors++; $display("FAIL rd_lat1_valid got=%b want=%b", rsp_valid_o, ACK); end
    step(1'b0, 1'b0, 0, 0, 1'b1);
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rd_lat2_valid got=%b want=1", rsp_valid_o); end
    checks++; if (rsp_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h want=deadbeef", rsp_rdata_o); end
    checks++; if (rsp_we_o !== 1'b0) begin errors++; $display("FAIL rd_we got=%b want=0", rsp_we_o); end
    idle(2, 1'b1);
    checks++; if (obs_q.size() != (ACK ? 2 : 1)) begin errors++; $display("FAIL wr_rd_count got=%0d want=%0d", obs_q.size(), ACK ? 2 : 1); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) send(1'b1, i, 32'h100 + i, 1'b1);
    idle(4, 1'b1);
    obs_q.delete(); pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, i, 0, 1'b1);
      checks++; if (last_rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got=%b want=1", i, last_rdy); end
    end
    idle(4, 1'b1);
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL b2b_count got=%0d want=8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_q[i].data !== 32'h100 + i || obs_q[i].we !== 1'b0) begin
          errors++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, obs_q[i].data, 32'h100 + i);
        end
        checks++;
        if (pop_cyc[i] != pop_cyc[0] + i) begin
          errors++; $display("FAIL b2b_cycle i=%0d got=%0d want=%0d", i, pop_cyc[i], pop_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int i = 0;
    int n = 0;
    obs_q.delete(); fires = 0;
    repeat (6) begin
      step(1'b1, 1'b0, i, 0, 1'b0);
      if (last_fire) i++;
    end
    checks++; if (fires != DEPTH) begin errors++; $display("FAIL bp_fires got=%0d want=%0d", fires, DEPTH); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b want=0", req_ready_o); end
    step(1'b1, 1'b0, i, 0, 1'b1);
    checks++; if (last_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready_pop_cycle got=%b want=0", last_rdy); end
    step(1'b1, 1'b0, i, 0, 1'b1);
    checks++; if (last_rdy !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b want=1", last_rdy); end
    if (last_fire) i++;
    while (i < 8 && n < 100) begin
      step(1'b1, 1'b0, i, 0, 1'b1);
      if (last_fire) i++;
      n++;
    end
    idle(5, 1'b1);
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL bp_count got=%0d want=8", obs_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (obs_q[k].data !== 32'h100 + k) begin
          errors++; $display("FAIL bp_data k=%0d got=%h want=%h", k, obs_q[k].data, 32'h100 + k);
        end
      end
    end
  endtask

  task automatic test_write_ack;
    rsp_t exp_q[$];
    rsp_t e;
    obs_q.delete();
    send(1'b1, 3, 32'h55, 1'b1);
    send(1'b0, 3, 0, 1'b1);
    send(1'b1, 3, 32'hAA, 1'b1);
    send(1'b0, 3, 0, 1'b1);
    idle(5, 1'b1);
`ifdef RAM_PORT_INITIATOR_WRITE_ACK_EN
    e.we = 1'b1; e.data = '0;       exp_q.push_back(e);
    e.we = 1'b0; e.data = 32'h55;   exp_q.push_back(e);
    e.we = 1'b1; e.data = '0;       exp_q.push_back(e);
    e.we = 1'b0; e.data = 32'hAA;   exp_q.push_back(e);
`else
    e.we = 1'b0; e.data = 32'h55;   exp_q.push_back(e);
    e.we = 1'b0; e.data = 32'hAA;   exp_q.push_back(e);
`endif
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ack_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL ack_seq k=%0d got=%b/%h want=%b/%h", k, obs_q[k].we, obs_q[k].data, exp_q[k].we, exp_q[k].data);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    obs_q.delete();
    send(1'b0, 0, 0, 1'b0);
    send(1'b0, 1, 0, 1'b0);
    send(1'b0, 2, 0, 1'b0);
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got=%b want=1", rsp_valid_o); end
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd3; req_wdata = 32'h777;
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid_drop got=%b want=0", rsp_valid_o); end
    checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL rmid_ram_we got=%b want=0", ram_we_o); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b want=1", req_ready_o); end
    @(posedge clk); cyc++; #1;
    idle(4, 1'b1);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_stale got=%0d want=0", obs_q.size()); end
    send(1'b0, 3, 0, 1'b1);
    idle(4, 1'b1);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 32'hAA) begin
      errors++; $display("FAIL rmid_reset_write got=%0d entries want=1 of 000000aa", obs_q.size());
    end
  endtask

  task automatic test_random;
    rsp_t exp_q[$];
    rsp_t e, r;
    int   ovf = 0;
    logic v, we, rr;
    int   a, d;
    for (int k = 16; k < 32; k++) begin
      send(1'b1, k, k * 7, 1'b1);
      sb_mem[k] = DATA_W'(k * 7);
    end
    idle(5, 1'b1);
    obs_q.delete();
    for (int n = 0; n < 10010; n++) begin
      v  = (n < 10000) && ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      a  = 16 + int'($urandom_range(0, 15));
      d  = int'($urandom);
      rr = (n >= 10000) || ($urandom_range(0, 3) != 0);
      step(v, we, a, d, rr);
      while (obs_q.size() > 0) begin
        r = obs_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_stray got=%b/%h want=no response", r.we, r.data);
        end else begin
          e = exp_q.pop_front();
          if (r !== e) begin
            errors++;
            if (errors < 20) $display("FAIL rnd_rsp n=%0d got=%b/%h want=%b/%h", n, r.we, r.data, e.we, e.data);
          end
        end
      end
      if (last_fire) begin
        if (we) begin
          sb_mem[a] = DATA_W'(d);
          if (ACK) begin e.we = 1'b1; e.data = '0; exp_q.push_back(e); end
        end else begin
          e.we = 1'b0; e.data = sb_mem[a]; exp_q.push_back(e);
        end
      end
      if (exp_q.size() > DEPTH) ovf++;
    end
    checks++; if (ovf != 0) begin errors++; $display("FAIL rnd_overflow got=%0d want=0", ovf); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_write_ack();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
